// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, reads a combinational ROM and queues {pc, instr}
// pairs for decode; execute redirects flush the queue and restart fetch.
module fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 27,
    parameter int DEPTH      = 4,
    parameter int RESET_PC   = 0,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [CW-1:0]         count
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [PW-1:0]         wr;
    logic [PW-1:0]         rd;
    logic [DATA_WIDTH-1:0] instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];
    logic                  push;
    logic                  pop;

    assign address   = pc;
    assign out_valid = (count != '0);
    assign out_instr = instr_q[rd];
    assign out_pc    = pc_q[rd];

    // A full queue still accepts a fetch when the head leaves this cycle
    assign pop  = out_valid & out_ready & ~redirect;
    assign push = ~redirect & ((count < CW'(DEPTH)) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= ADDR_WIDTH'(RESET_PC);
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else if (redirect) begin
            pc    <= redirect_pc;
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc <= pc + 1'b1;
                wr <= wr + 1'b1;
            end
            if (pop) begin
                rd <= rd + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset: contents are only observed when counted
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr] <= data;
            pc_q[wr]    <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table plus scoreboarded corner sequences.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [26:0] address;
    logic [31:0] data;
    logic        redirect;
    logic [26:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [26:0] out_pc;
    logic [2:0]  count;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic [26:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [26:0] rpc;
        int          ecnt;
        logic        evalid;
        logic [26:0] eaddr;
    } vec_t;

    ent_t        m_q[$];
    logic [26:0] m_pc;
    vec_t        tv[15];

    fetch_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .data        (data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .count       (count)
    );

    function automatic logic [31:0] rom(input logic [26:0] a);
        return {5'b0, a} + 32'h100;
    endfunction

    assign data = rom(address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input int c, input logic v,
                                input int a);
        vec_t t;
        t.rdy    = r;
        t.redir  = 1'b0;
        t.rpc    = '0;
        t.ecnt   = c;
        t.evalid = v;
        t.eaddr  = 27'(a);
        return t;
    endfunction

    // One cycle starting at a falling edge: drive, check, advance the model
    task automatic tick(input logic rdy, input logic redir,
                        input logic [26:0] rpc, input logic chk,
                        input int ecnt, input logic evalid,
                        input logic [26:0] eaddr);
        logic do_pop;
        logic do_push;
        out_ready   = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        if (chk) begin
            check("vec_count", 32'(count), 32'(ecnt));
            check("vec_valid", 32'(out_valid), 32'(evalid));
            check("vec_addr", 32'(address), 32'(eaddr));
        end
        check("sb_addr", 32'(address), 32'(m_pc));
        check("sb_count", 32'(count), 32'(m_q.size()));
        if (m_q.size() != 0) begin
            check("sb_valid", 32'(out_valid), 32'd1);
            check("sb_pc", 32'(out_pc), 32'(m_q[0].pc));
            check("sb_instr", out_instr, m_q[0].ins);
        end else begin
            check("sb_valid", 32'(out_valid), 32'd0);
        end
        if (redir) begin
            m_q.delete();
            m_pc = rpc;
        end else begin
            do_pop  = (m_q.size() != 0) && rdy;
            do_push = (m_q.size() < 4) || do_pop;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back('{pc: m_pc, ins: rom(m_pc)});
                m_pc = m_pc + 27'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input logic rdy);
        tick(rdy, 1'b0, '0, 1'b0, 0, 1'b0, '0);
    endtask

    initial begin
        logic [26:0] wrap_seq [3];
        pass_cnt    = 0;
        total_cnt   = 0;
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        m_pc        = '0;

        tv[0]  = mk(0, 0, 0, 0);
        tv[1]  = mk(0, 1, 1, 1);
        tv[2]  = mk(0, 2, 1, 2);
        tv[3]  = mk(0, 3, 1, 3);
        tv[4]  = mk(0, 4, 1, 4);
        tv[5]  = mk(0, 4, 1, 4);
        tv[6]  = mk(0, 4, 1, 4);
        tv[7]  = mk(0, 4, 1, 4);
        tv[8]  = mk(1, 4, 1, 4);
        tv[9]  = mk(0, 4, 1, 5);
        tv[10] = mk(1, 4, 1, 5);
        tv[11] = mk(1, 4, 1, 6);
        tv[12] = mk(1, 4, 1, 7);
        tv[13] = mk(1, 4, 1, 8);
        tv[14] = mk(1, 4, 1, 9);

        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stall fills to DEPTH, one-cycle pop/push at full, then stream out
        foreach (tv[i])
            tick(tv[i].rdy, tv[i].redir, tv[i].rpc, 1'b1,
                 tv[i].ecnt, tv[i].evalid, tv[i].eaddr);
        for (int i = 0; i < 6; i++) run(1'b1);

        // Build count=3 behind a redirect, then redirect again
        tick(1'b1, 1'b1, 27'h20, 1'b0, 0, 1'b0, '0);
        tick(1'b0, 1'b0, '0, 1'b1, 0, 1'b0, 27'h20);
        tick(1'b0, 1'b0, '0, 1'b1, 1, 1'b1, 27'h21);
        tick(1'b0, 1'b0, '0, 1'b1, 2, 1'b1, 27'h22);
        tick(1'b0, 1'b1, 27'h40, 1'b1, 3, 1'b1, 27'h23);
        tick(1'b0, 1'b0, '0, 1'b1, 0, 1'b0, 27'h40);
        check("redir_pc", 32'(out_pc), 32'h40);
        check("redir_instr", out_instr, 32'h140);
        check("redir_valid", 32'(out_valid), 32'd1);

        // PC wrap at the top of the address space
        tick(1'b1, 1'b1, 27'h7FFFFFE, 1'b0, 0, 1'b0, '0);
        tick(1'b1, 1'b0, '0, 1'b1, 0, 1'b0, 27'h7FFFFFE);
        wrap_seq[0] = 27'h7FFFFFE;
        wrap_seq[1] = 27'h7FFFFFF;
        wrap_seq[2] = 27'h0000000;
        for (int i = 0; i < 3; i++) begin
            check("wrap_pc", 32'(out_pc), 32'(wrap_seq[i]));
            run(1'b1);
        end

        // Asynchronous reset with two entries queued
        tick(1'b0, 1'b1, 27'h100, 1'b0, 0, 1'b0, '0);
        run(1'b0);
        run(1'b0);
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_addr", 32'(address), 32'd0);
        m_q.delete();
        m_pc = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming from reset: one per cycle, count holds at 1
        tick(1'b1, 1'b0, '0, 1'b1, 0, 1'b0, 27'd0);
        tick(1'b1, 1'b0, '0, 1'b1, 1, 1'b1, 27'd1);
        tick(1'b1, 1'b0, '0, 1'b1, 1, 1'b1, 27'd2);
        tick(1'b1, 1'b0, '0, 1'b1, 1, 1'b1, 27'd3);
        tick(1'b1, 1'b0, '0, 1'b1, 1, 1'b1, 27'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
